// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, default
// link constants and the parity helper used by the receiver.
package uart_pkg;

   localparam int UART_CLKS_PER_BIT = 434;
   localparam int UART_DATA_BITS    = 7;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   // Parity bit a transmitter would append to this data word.
   // Unused upper bits are zero, so they do not change the XOR.
   function automatic logic calc_parity(input logic [31:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous RX pin into the clock domain and flags falling
// edges of the synchronised line. The edge flag is held off for a few cycles
// after reset so that a line already low at release never looks like a start.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic       meta;
   logic       rx_prev;
   logic [2:0] settle;

   // Two-flop synchroniser plus a one-cycle delayed copy for edge detection.
   // Everything resets to the idle-high line level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         meta    <= rx;
         rx_s    <= meta;
         rx_prev <= rx_s;
      end
   end

   // Counts the cycles until rx_prev reflects the real pin after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         settle <= 3'b000;
      end else begin
         settle <= {settle[1:0], 1'b1};
      end
   end

   assign fall = rx_prev & ~rx_s & settle[2];

endmodule

// File: rtl/uart_rx_frame.sv
// Standalone UART frame receiver: start bit, DATA_BITS data bits LSB first,
// optional parity bit, one stop bit. Each bit is sampled at its midpoint.
// Reset asserts asynchronously and is released synchronously.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in_bit,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 is_received,
   output logic                 parity,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS) + 1;

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

   logic [1:0] rst_sync;
   logic       rst_int;
   logic       rx_s;
   logic       fall;

   uart_state_e          state_q, state_next;
   logic [CNT_W-1:0]     cnt_q, cnt_next;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_next;
   logic [DATA_BITS-1:0] shift_q, shift_next;
   logic                 par_bit_q, par_bit_next;

   logic [DATA_BITS-1:0] data_next;
   logic                 received_next;
   logic                 parity_next;
   logic                 parity_err_next;
   logic                 frame_err_next;
   logic                 busy_next;

   // Reset synchroniser: assert immediately, release two clocks later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_int = rst_sync[1];

   uart_rx_sync u_sync (
      .clk  (clk),
      .rst  (rst_int),
      .rx   (rx_in_bit),
      .rx_s (rx_s),
      .fall (fall)
   );

   // Next-state and datapath decode; the counter only moves outside IDLE
   // and is always reloaded explicitly when it reaches zero.
   always_comb begin
      state_next      = state_q;
      cnt_next        = cnt_q;
      bit_idx_next    = bit_idx_q;
      shift_next      = shift_q;
      par_bit_next    = par_bit_q;
      data_next       = data_out;
      received_next   = 1'b0;
      parity_next     = parity;
      parity_err_next = parity_err;
      frame_err_next  = frame_err;
      busy_next       = busy;

      if (state_q != IDLE && cnt_q != '0) begin
         cnt_next = cnt_q - CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_next = START;
               cnt_next   = HALF_LOAD;
               busy_next  = 1'b1;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  state_next = IDLE;
                  busy_next  = 1'b0;
               end else begin
                  state_next   = DATA;
                  cnt_next     = FULL_LOAD;
                  bit_idx_next = '0;
               end
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shift_next = (shift_q >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
               cnt_next   = FULL_LOAD;
               if (bit_idx_q == LAST_IDX) begin
                  state_next = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_next = bit_idx_q + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (cnt_q == '0) begin
               par_bit_next = rx_s;
               cnt_next     = FULL_LOAD;
               state_next   = STOP;
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               state_next     = IDLE;
               received_next  = 1'b1;
               busy_next      = 1'b0;
               data_next      = shift_q;
               frame_err_next = ~rx_s;
               if (PARITY_EN != 0) begin
                  parity_next     = par_bit_q;
                  parity_err_next = calc_parity(32'(shift_q), PARITY_ODD != 0) != par_bit_q;
               end else begin
                  parity_next     = 1'b0;
                  parity_err_next = 1'b0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_int) begin
      if (!rst_int) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         par_bit_q   <= 1'b0;
         data_out    <= '0;
         is_received <= 1'b0;
         parity      <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_next;
         cnt_q       <= cnt_next;
         bit_idx_q   <= bit_idx_next;
         shift_q     <= shift_next;
         par_bit_q   <= par_bit_next;
         data_out    <= data_next;
         is_received <= received_next;
         parity      <= parity_next;
         parity_err  <= parity_err_next;
         frame_err   <= frame_err_next;
         busy        <= busy_next;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: a table of frames with hand-computed
// results, plus hand-written sequences for reset, break, glitch and
// back-to-back frames.
module tb_uart_rx_frame;

   localparam int CPB = 434;
   localparam int DB  = 7;
   localparam int LAT = 3 + CPB / 2 + (DB + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_in_bit = 1'b1;
   logic [DB-1:0] data_out;
   logic          is_received;
   logic          parity;
   logic          parity_err;
   logic          frame_err;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   int strobe_n = 0;
   int strobe_at[$];
   logic [DB-1:0] strobe_data[$];
   logic [2:0]    strobe_flags[$];

   typedef struct {
      string         name;
      logic [DB-1:0] data;
      logic          par_bit;
      logic          stop_bit;
      logic          exp_par;
      logic          exp_perr;
      logic          exp_ferr;
   } vec_t;

   vec_t vecs[6];

   uart_rx_frame #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB),
      .PARITY_EN    (1),
      .PARITY_ODD   (0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in_bit   (rx_in_bit),
      .data_out    (data_out),
      .is_received (is_received),
      .parity      (parity),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   // Records every strobe with its cycle and the values valid alongside it.
   always @(negedge clk) begin
      if (is_received) begin
         strobe_at.push_back(cycle);
         strobe_data.push_back(data_out);
         strobe_flags.push_back({parity, parity_err, frame_err});
         strobe_n++;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic check_latency(input string name, input int lat);
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         errors++;
         $display("[TB] FAIL %s: latency %0d expected %0d +/-1", name, lat, LAT);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_in_bit = b;
      wait_cycles(CPB);
   endtask

   // Drives one full frame; the line is left at the stop-bit level.
   task automatic apply_stimulus(input logic [DB-1:0] data, input logic par_bit,
                                 input logic stop_bit, output int edge_cyc);
      edge_cyc = cycle;
      send_bit(1'b0);
      for (int i = 0; i < DB; i++) send_bit(data[i]);
      send_bit(par_bit);
      send_bit(stop_bit);
   endtask

   task automatic check_frame(input string name, input logic [DB-1:0] data,
                              input logic par_bit, input logic stop_bit,
                              input logic exp_par, input logic exp_perr,
                              input logic exp_ferr);
      int n0;
      int e;
      n0 = strobe_n;
      apply_stimulus(data, par_bit, stop_bit, e);
      rx_in_bit = 1'b1;
      wait_cycles(CPB);
      check_output({name, "_strobes"}, strobe_n - n0, 1);
      if (strobe_n > n0) begin
         check_latency({name, "_latency"}, strobe_at[n0] - e);
         check_output({name, "_data"}, 32'(strobe_data[n0]), 32'(data));
         check_output({name, "_flags"}, 32'(strobe_flags[n0]),
                      32'({exp_par, exp_perr, exp_ferr}));
      end
      check_output({name, "_busy"}, 32'(busy), 0);
   endtask

   task automatic check_all_zero(input string name);
      check_output({name, "_data"}, 32'(data_out), 0);
      check_output({name, "_strobe"}, 32'(is_received), 0);
      check_output({name, "_flags"}, 32'({parity, parity_err, frame_err}), 0);
      check_output({name, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int n0;
      int e;

      vecs[0] = '{"even_ok",   7'b0010111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"par1_ok",   7'b1100001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{"par_err",   7'b1100001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{"all_ones",  7'b1111111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{"alt_ok",    7'b0101010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{"alt_perr",  7'b1010101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst = 1'b0;
      rx_in_bit = 1'b1;
      wait_cycles(5);
      check_all_zero("reset");
      rst = 1'b1;
      wait_cycles(10);

      for (int v = 0; v < 6; v++) begin
         check_frame(vecs[v].name, vecs[v].data, vecs[v].par_bit, vecs[v].stop_bit,
                     vecs[v].exp_par, vecs[v].exp_perr, vecs[v].exp_ferr);
      end

      // Reset in the middle of data bit 3 (a 0 bit of 7'b0010111), line low
      // across release so it must not count as a start.
      $display("[TB] reset mid-frame");
      n0 = strobe_n;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      rx_in_bit = 1'b0;
      wait_cycles(CPB / 2);
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      wait_cycles(20);
      rst = 1'b1;
      wait_cycles(CPB);
      check_output("low_release_busy", 32'(busy), 0);
      rx_in_bit = 1'b1;
      wait_cycles(2 * CPB);
      check_output("mid_reset_strobes", strobe_n - n0, 0);
      check_frame("after_reset", 7'b1010101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Break: zero data, stop bit low, line low for five bit times.
      $display("[TB] break");
      n0 = strobe_n;
      apply_stimulus(7'b0000000, 1'b0, 1'b0, e);
      wait_cycles(4 * CPB);
      check_output("break_strobes", strobe_n - n0, 1);
      if (strobe_n > n0) begin
         check_latency("break_latency", strobe_at[n0] - e);
         check_output("break_data", 32'(strobe_data[n0]), 0);
         check_output("break_flags", 32'(strobe_flags[n0]), 32'(3'b001));
      end
      check_output("break_busy", 32'(busy), 0);
      rx_in_bit = 1'b1;
      wait_cycles(2 * CPB);
      check_output("break_no_retrigger", strobe_n - n0, 1);

      // Glitch: 100-cycle low pulse is rejected at the start-bit midpoint.
      $display("[TB] glitch");
      n0 = strobe_n;
      rx_in_bit = 1'b0;
      wait_cycles(100);
      rx_in_bit = 1'b1;
      check_output("glitch_busy_early", 32'(busy), 1);
      wait_cycles(115);
      check_output("glitch_busy_215", 32'(busy), 1);
      wait_cycles(10);
      check_output("glitch_busy_225", 32'(busy), 0);
      wait_cycles(10 * CPB);
      check_output("glitch_strobes", strobe_n - n0, 0);

      // Back-to-back frames with no idle time between them.
      $display("[TB] back-to-back");
      n0 = strobe_n;
      apply_stimulus(7'b0010111, 1'b0, 1'b1, e);
      apply_stimulus(7'b1100001, 1'b1, 1'b1, e);
      rx_in_bit = 1'b1;
      wait_cycles(CPB);
      check_output("b2b_strobes", strobe_n - n0, 2);
      if (strobe_n > n0 + 1) begin
         check_output("b2b_spacing", strobe_at[n0 + 1] - strobe_at[n0], 10 * CPB);
         check_output("b2b_data0", 32'(strobe_data[n0]), 32'(7'b0010111));
         check_output("b2b_flags0", 32'(strobe_flags[n0]), 32'(3'b000));
         check_output("b2b_data1", 32'(strobe_data[n0 + 1]), 32'(7'b1100001));
         check_output("b2b_flags1", 32'(strobe_flags[n0 + 1]), 32'(3'b100));
      end
      check_output("b2b_busy", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
